// File: rtl/mips_pkg.sv
// Shared widths and constants for the register file / scoreboard slice.
package mips_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int CNT_W  = 2;

    localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/sb_counter.sv
// Saturating up/down count of in-flight writes for one register.
module sb_counter #(
    parameter int CNT_W = mips_pkg::CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             dec,
    output logic [CNT_W-1:0] cnt,
    output logic             sat_hi,
    output logic             zero
);

    logic [CNT_W-1:0] r_cnt;

    assign cnt    = r_cnt;
    assign sat_hi = &r_cnt;
    assign zero   = (r_cnt == '0);

    // Simultaneous inc and dec cancel; both ends hold instead of wrapping.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (inc && !dec && !sat_hi) begin
            r_cnt <= r_cnt + 1'b1;
        end else if (dec && !inc && !zero) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

endmodule

// File: rtl/reg_file_sb.sv
// Register file with write bypass and a per-register in-flight-write scoreboard.
module reg_file_sb
    import mips_pkg::*;
#(
    parameter int DATA_W = mips_pkg::DATA_W,
    parameter int ADDR_W = mips_pkg::ADDR_W,
    parameter int CNT_W  = mips_pkg::CNT_W
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [ADDR_W-1:0]    rs_addr,
    input  logic [ADDR_W-1:0]    rt_addr,
    input  logic                 rs_used,
    input  logic                 rt_used,
    output logic [DATA_W-1:0]    rs_data,
    output logic [DATA_W-1:0]    rt_data,
    input  logic                 issue_valid,
    input  logic [ADDR_W-1:0]    issue_dst,
    input  logic                 wr_en,
    input  logic [ADDR_W-1:0]    wr_addr,
    input  logic [DATA_W-1:0]    wr_data,
    output logic                 stall,
    output logic [2**ADDR_W-1:0] busy_vec,
    output logic                 sb_err
);

    localparam int NREG = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] R0 = ADDR_W'(REG_ZERO);

    logic [DATA_W-1:0] r_regs [NREG];
    logic              r_err;

    logic [CNT_W-1:0]  w_cnt [NREG];
    logic [NREG-1:0]   w_zero;
    logic [NREG-1:0]   w_sat;

    logic w_wb;
    logic w_rs_rdy;
    logic w_rt_rdy;
    logic w_dst_full;
    logic w_accept;

    assign w_wb = wr_en && (wr_addr != R0);

    assign w_cnt[0]  = '0;
    assign w_zero[0] = 1'b1;
    assign w_sat[0]  = 1'b0;

    for (genvar gi = 1; gi < NREG; gi++) begin : g_cnt
        sb_counter #(.CNT_W(CNT_W)) u_cnt (
            .clk    (clk),
            .rst    (rst),
            .inc    (w_accept && (issue_dst == ADDR_W'(gi))),
            .dec    (w_wb && (wr_addr == ADDR_W'(gi))),
            .cnt    (w_cnt[gi]),
            .sat_hi (w_sat[gi]),
            .zero   (w_zero[gi])
        );
    end

    // A source with exactly one write left is ready if that write lands now.
    assign w_rs_rdy = (rs_addr == R0) || w_zero[rs_addr] ||
                      ((w_cnt[rs_addr] == CNT_W'(1)) && w_wb &&
                       (wr_addr == rs_addr));
    assign w_rt_rdy = (rt_addr == R0) || w_zero[rt_addr] ||
                      ((w_cnt[rt_addr] == CNT_W'(1)) && w_wb &&
                       (wr_addr == rt_addr));

    assign w_dst_full = (issue_dst != R0) && w_sat[issue_dst] &&
                        !(w_wb && (wr_addr == issue_dst));

    assign stall = issue_valid &&
                   ((rs_used && !w_rs_rdy) ||
                    (rt_used && !w_rt_rdy) ||
                    w_dst_full);

    assign w_accept = issue_valid && !stall;

    always_comb begin
        rs_data = r_regs[rs_addr];
        if (rs_addr == R0) begin
            rs_data = '0;
        end else if (w_wb && (wr_addr == rs_addr)) begin
            rs_data = wr_data;
        end
    end

    always_comb begin
        rt_data = r_regs[rt_addr];
        if (rt_addr == R0) begin
            rt_data = '0;
        end else if (w_wb && (wr_addr == rt_addr)) begin
            rt_data = wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_wb) begin
            r_regs[wr_addr] <= wr_data;
        end
    end

    // A write-back nobody issued for is a scoreboard error, unless an
    // issue to the same register is accepted in that cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_err <= 1'b0;
        end else if (w_wb && w_zero[wr_addr] &&
                     !(w_accept && (issue_dst == wr_addr))) begin
            r_err <= 1'b1;
        end
    end

    assign sb_err   = r_err;
    assign busy_vec = ~w_zero;

endmodule

// File: tb/tb_reg_file_sb.sv
// Directed vector bench for reg_file_sb: operand reads, bypass, scoreboard stall and error.
module tb_reg_file_sb;

    logic        clk;
    logic        rst;
    logic [4:0]  rs_addr, rt_addr;
    logic        rs_used, rt_used;
    logic [31:0] rs_data, rt_data;
    logic        issue_valid;
    logic [4:0]  issue_dst;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic        stall;
    logic [31:0] busy_vec;
    logic        sb_err;

    int n_pass;
    int n_total;

    reg_file_sb dut (
        .clk         (clk),
        .rst         (rst),
        .rs_addr     (rs_addr),
        .rt_addr     (rt_addr),
        .rs_used     (rs_used),
        .rt_used     (rt_used),
        .rs_data     (rs_data),
        .rt_data     (rt_data),
        .issue_valid (issue_valid),
        .issue_dst   (issue_dst),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .stall       (stall),
        .busy_vec    (busy_vec),
        .sb_err      (sb_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        chk;
        logic        rst;
        logic [4:0]  rsa;
        logic        rsu;
        logic [4:0]  rta;
        logic        rtu;
        logic        iv;
        logic [4:0]  dst;
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic [31:0] e_rs;
        logic [31:0] e_rt;
        logic        e_stall;
        logic [31:0] e_busy;
        logic        e_err;
    } vec_t;

    vec_t tbl [28];

    function automatic vec_t mk(
        input logic chk, input logic r,
        input logic [4:0] rsa, input logic rsu,
        input logic [4:0] rta, input logic rtu,
        input logic iv, input logic [4:0] dst,
        input logic we, input logic [4:0] wa, input logic [31:0] wd,
        input logic [31:0] e_rs, input logic [31:0] e_rt,
        input logic e_stall, input logic [31:0] e_busy, input logic e_err);
        vec_t v;
        v.chk = chk; v.rst = r;
        v.rsa = rsa; v.rsu = rsu; v.rta = rta; v.rtu = rtu;
        v.iv = iv; v.dst = dst; v.we = we; v.wa = wa; v.wd = wd;
        v.e_rs = e_rs; v.e_rt = e_rt; v.e_stall = e_stall;
        v.e_busy = e_busy; v.e_err = e_err;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        @(negedge clk);
        rst = v.rst;
        rs_addr = v.rsa; rs_used = v.rsu;
        rt_addr = v.rta; rt_used = v.rtu;
        issue_valid = v.iv; issue_dst = v.dst;
        wr_en = v.we; wr_addr = v.wa; wr_data = v.wd;
        #1;
    endtask

    task automatic check_vec(input string tag, input vec_t v);
        check({tag, ".rs_data"}, rs_data, v.e_rs);
        check({tag, ".rt_data"}, rt_data, v.e_rt);
        check({tag, ".stall"}, 32'(stall), 32'(v.e_stall));
        check({tag, ".busy_vec"}, busy_vec, v.e_busy);
        check({tag, ".sb_err"}, 32'(sb_err), 32'(v.e_err));
    endtask

    initial begin
        n_pass = 0;
        n_total = 0;
        rst = 1'b1;
        rs_addr = '0; rt_addr = '0; rs_used = 1'b0; rt_used = 1'b0;
        issue_valid = 1'b0; issue_dst = '0;
        wr_en = 1'b0; wr_addr = '0; wr_data = '0;

        //          chk r  rsa rsu rta rtu iv dst we wa wd  | rs rt stall busy err
        tbl[0]  = mk(0,1, 0,0, 0,0, 0,0, 0,0,0, 0,0,0,0,0);
        tbl[1]  = mk(1,0, 0,0, 0,0, 0,0, 0,0,0, 0,0,0,0,0);
        tbl[2]  = mk(1,0, 0,0, 0,0, 1,5, 0,0,0, 0,0,0,0,0);
        tbl[3]  = mk(1,0, 5,0, 0,0, 0,0, 1,5,32'hDEADBEEF,
                     32'hDEADBEEF,0,0,32'h20,0);
        tbl[4]  = mk(1,0, 5,0, 0,0, 0,0, 0,0,0, 32'hDEADBEEF,0,0,0,0);
        tbl[5]  = mk(1,0, 0,0, 0,0, 0,0, 1,0,32'h1234, 0,0,0,0,0);
        tbl[6]  = mk(1,0, 0,0, 0,0, 0,0, 0,0,0, 0,0,0,0,0);
        tbl[7]  = mk(1,0, 0,0, 0,0, 1,8, 0,0,0, 0,0,0,0,0);
        tbl[8]  = mk(1,0, 8,1, 0,0, 1,0, 0,0,0, 0,0,1,32'h100,0);
        tbl[9]  = mk(1,0, 8,1, 8,0, 1,0, 1,8,32'h55,
                     32'h55,32'h55,0,32'h100,0);
        tbl[10] = mk(1,0, 8,0, 0,0, 0,0, 0,0,0, 32'h55,0,0,0,0);
        tbl[11] = mk(1,0, 0,0, 0,0, 1,3, 0,0,0, 0,0,0,0,0);
        tbl[12] = mk(1,0, 0,0, 0,0, 1,3, 0,0,0, 0,0,0,32'h8,0);
        tbl[13] = mk(1,0, 0,0, 0,0, 1,3, 0,0,0, 0,0,0,32'h8,0);
        tbl[14] = mk(1,0, 0,0, 0,0, 1,3, 0,0,0, 0,0,1,32'h8,0);
        tbl[15] = mk(1,0, 0,0, 0,0, 1,3, 1,3,32'h77, 0,0,0,32'h8,0);
        tbl[16] = mk(1,0, 0,0, 3,0, 1,3, 0,0,0, 0,32'h77,1,32'h8,0);
        tbl[17] = mk(1,0, 0,0, 0,0, 1,9, 0,0,0, 0,0,0,32'h8,0);
        tbl[18] = mk(1,0, 9,0, 0,0, 1,9, 1,9,32'h99,
                     32'h99,0,0,32'h208,0);
        tbl[19] = mk(1,0, 9,0, 0,0, 0,0, 0,0,0, 32'h99,0,0,32'h208,0);
        tbl[20] = mk(1,0, 12,0, 0,0, 0,0, 1,12,32'hC,
                     32'hC,0,0,32'h208,0);
        tbl[21] = mk(1,0, 12,0, 0,0, 0,0, 0,0,0, 32'hC,0,0,32'h208,1);
        tbl[22] = mk(1,0, 0,0, 0,0, 0,0, 0,0,0, 0,0,0,32'h208,1);
        tbl[23] = mk(1,0, 0,0, 0,0, 1,4, 0,0,0, 0,0,0,32'h208,1);
        tbl[24] = mk(1,1, 0,0, 0,0, 1,21, 1,20,32'hAA, 0,0,0,32'h218,1);
        tbl[25] = mk(1,0, 3,1, 9,1, 1,0, 0,0,0, 0,0,0,0,0);
        tbl[26] = mk(1,0, 20,0, 4,0, 0,0, 1,4,32'h1, 0,32'h1,0,0,0);
        tbl[27] = mk(1,0, 4,0, 0,0, 0,0, 0,0,0, 32'h1,0,0,0,1);

        for (int i = 0; i < 28; i++) begin
            drive(tbl[i]);
            if (tbl[i].chk) begin
                check_vec($sformatf("v%0d", i), tbl[i]);
            end
        end

        // Two writes outstanding to r7: the first write-back is not enough.
        drive(mk(0,1, 0,0, 0,0, 0,0, 0,0,0, 0,0,0,0,0));
        drive(mk(0,0, 0,0, 0,0, 1,7, 0,0,0, 0,0,0,0,0));
        drive(mk(0,0, 0,0, 0,0, 1,7, 0,0,0, 0,0,0,0,0));
        drive(mk(0,0, 7,1, 0,0, 1,0, 1,7,32'h70, 0,0,0,0,0));
        check("h_cnt2.stall", 32'(stall), 32'd1);
        check("h_cnt2.busy", busy_vec, 32'h80);
        drive(mk(0,0, 7,1, 7,1, 1,0, 1,7,32'h71, 0,0,0,0,0));
        check("h_cnt1.stall", 32'(stall), 32'd0);
        check("h_cnt1.rs", rs_data, 32'h71);
        drive(mk(0,0, 7,0, 0,0, 0,0, 1,7,32'h72, 0,0,0,0,0));
        check("h_cnt0.busy", busy_vec, 32'h0);
        check("h_cnt0.err", 32'(sb_err), 32'd0);
        drive(mk(0,0, 7,0, 0,0, 1,7, 0,0,0, 0,0,0,0,0));
        check("h_under.err", 32'(sb_err), 32'd1);
        check("h_under.rs", rs_data, 32'h72);
        drive(mk(0,0, 0,0, 0,0, 0,0, 0,0,0, 0,0,0,0,0));
        check("h_reissue.busy", busy_vec, 32'h80);

        // Same-cycle issue and write-back at counter 0 is not an error.
        drive(mk(0,1, 0,0, 0,0, 0,0, 0,0,0, 0,0,0,0,0));
        drive(mk(0,0, 0,0, 0,0, 1,11, 1,11,32'hB, 0,0,0,0,0));
        drive(mk(0,0, 11,0, 0,0, 0,0, 0,0,0, 0,0,0,0,0));
        check("h_pair0.err", 32'(sb_err), 32'd0);
        check("h_pair0.busy", busy_vec, 32'h0);
        check("h_pair0.rs", rs_data, 32'hB);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/reg_file_sb.md
REG_FILE_SB -- requirements
Module: reg_file_sb

Interface
REQ-001 The block SHALL take parameter DATA_W, default 32, meaning register width.
REQ-002 The block SHALL take parameter ADDR_W, default 5, meaning register address width (32 registers).
REQ-003 The block SHALL take parameter CNT_W, default 2, meaning in-flight-write counter width per register (max 3 outstanding).
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 rs_addr, rt_addr  input  ADDR_W  source register addresses from decode.
REQ-007 rs_used, rt_used  input  1  the corresponding source is consumed by the decoding instruction.
REQ-008 rs_data, rt_data  output  DATA_W  source operand values.
REQ-009 issue_valid  input  1  the decoding instruction requests issue.
REQ-010 issue_dst  input  ADDR_W  destination register of the issuing instruction (the rt/rd-selected write address).
REQ-011 wr_en  input  1  write-back strobe.
REQ-012 wr_addr  input  ADDR_W  write-back destination.
REQ-013 wr_data  input  DATA_W  write-back value.
REQ-014 stall  output  1  issue blocked this cycle (combinational).
REQ-015 busy_vec  output  2**ADDR_W  bit i = register i has counter != 0.
REQ-016 sb_err  output  1  sticky flag: write-back to a register with counter 0.

Function
REQ-017 Reads SHALL be combinational: rs_data = reg[rs_addr], same for rt.
REQ-018 Register 0 SHALL always read 0; writes to it are discarded; its counter stays 0; it never stalls.
REQ-019 Write bypass: when wr_en=1, wr_addr!=0 and wr_addr equals a source address, that source output SHALL equal wr_data in the same cycle.
REQ-020 A write with wr_en=1, wr_addr!=0 SHALL update reg[wr_addr] at the next edge, regardless of counter value.
REQ-021 Source ready SHALL mean: address 0, or counter==0, or counter==1 with wr_en=1 and wr_addr equal to that source this cycle.
REQ-022 stall SHALL be 1 when issue_valid=1 and (rs_used and rs not ready, or rt_used and rt not ready, or issue_dst!=0 with counter[issue_dst] at maximum 2**CNT_W-1 and no same-cycle write-back to it).
REQ-023 Issue SHALL be accepted when issue_valid=1 and stall=0; stall SHALL be 0 when issue_valid=0.
REQ-024 Accepted issue with issue_dst!=0 SHALL increment counter[issue_dst] by 1.
REQ-025 wr_en=1, wr_addr!=0, counter>0 SHALL decrement counter[wr_addr] by 1.
REQ-026 Same-cycle accepted issue and write-back to the same register SHALL leave its counter unchanged.
REQ-027 wr_en=1, wr_addr!=0, counter==0 (and no same-cycle issue to it) SHALL leave the counter 0 and set sb_err, which holds until reset.
REQ-028 Counters SHALL never wrap in either direction.
REQ-029 busy_vec SHALL reflect registered counter state (updates one cycle after issue/write-back).

Reset
REQ-030 With rst=1 at an edge, all registers, all counters and sb_err SHALL become 0; the write and issue presented in that cycle SHALL be discarded.
REQ-031 After reset, rs_data=rt_data=0, busy_vec=0, sb_err=0, and stall depends only on current inputs (0 for any issue).
REQ-032 Reset asserted mid-operation SHALL drop all in-flight tracking; later write-backs to those registers SHALL set sb_err.

Structure
REQ-033 DATA_W, ADDR_W, CNT_W defaults and constant REG_ZERO (5'd0) SHALL live in shared package mips_pkg.
REQ-034 Per-register saturating up/down counter SHALL be sub-module sb_counter (inc, dec, sat_hi, zero outputs), instantiated 31 times (registers 1..31).

Verification
REQ-035 Reset, then write reg 5 = 0xDEADBEEF -> next cycle rs_addr=5 reads 0xDEADBEEF; write reg 0 = 0x1234 -> reg 0 reads 0.
REQ-036 Issue dst=8; next cycle issue with rs_addr=8, rs_used=1 -> stall=1; cycle where wr_en, wr_addr=8, wr_data=0x55 -> stall=0, rs_data=0x55, busy_vec[8] clears next cycle.
REQ-037 Three accepted issues to dst=3 -> counter 3; fourth issue dst=3 -> stall=1; same with wr_addr=3 write-back -> accepted, counter stays 3.
REQ-038 Accepted issue dst=9 and wr_en wr_addr=9 same cycle with counter 1 -> counter remains 1, busy_vec[9]=1, sb_err=0.
REQ-039 wr_en wr_addr=12 with counter 0 -> reg 12 written, sb_err=1 and stays 1 until rst.
REQ-040 Issue dst=4, assert rst mid-flight -> busy_vec=0, all regs 0, sb_err=0; later write-back to 4 -> sb_err=1.
